// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// uart_tx_arbiter_if : requester/transmitter bus of the UART TX arbiter
// Rev 1.0
// ============================================================================
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
) ();
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic                 en;
  logic [NREQ-1:0]      req;
  logic [8*NREQ-1:0]    req_data;
  logic [NREQ-1:0]      grant;
  logic [7:0]           Tx_DATA;
  logic                 Tx_WR;
  logic                 Tx_BUSY;
  logic [OW-1:0]        owner;
  logic                 active;
  logic                 timeout_err;

  modport master (
    input  en, req, req_data, Tx_BUSY,
    output grant, Tx_DATA, Tx_WR, owner, active, timeout_err
  );

  modport slave (
    output en, req, req_data, Tx_BUSY,
    input  grant, Tx_DATA, Tx_WR, owner, active, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// uart_tx_arbiter : round-robin arbiter feeding bytes to one UART transmitter
// Optional start timeout enabled by defining UART_ARB_TIMEOUT_EN.
// Rev 1.0
// ============================================================================
module uart_tx_arbiter #(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 1023
) (
  input  wire logic         clk,
  input  wire logic         reset,
  uart_tx_arbiter_if.master bus
);
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("uart_tx_arbiter: NREQ must be 2..8");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("uart_tx_arbiter: TIMEOUT_CYC must be 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD       = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  logic [OW-1:0]   r_rr_ptr;
  logic [OW-1:0]   r_owner;
  logic [7:0]      r_tx_data;
  logic [NREQ-1:0] r_grant;
  logic            r_tx_wr;
  logic            r_active;

  logic [OW-1:0]   w_winner;
  logic [OW-1:0]   w_next_ptr;
  logic [7:0]      w_data;
  logic [NREQ-1:0] w_onehot;
  int              w_dist;
  int              w_best;

  // Winner is the requester with the smallest circular distance above rr_ptr.
  always_comb begin
    w_winner = r_rr_ptr;
    w_best   = NREQ;
    w_dist   = 0;
    for (int j = 0; j < NREQ; j++) begin
      if (bus.req[j]) begin
        if (j >= int'(r_rr_ptr)) w_dist = j - int'(r_rr_ptr);
        else                     w_dist = j + NREQ - int'(r_rr_ptr);
        if (w_dist < w_best) begin
          w_best   = w_dist;
          w_winner = OW'(j);
        end
      end
    end
  end

  always_comb begin
    w_data   = 8'h00;
    w_onehot = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (OW'(j) == w_winner) begin
        w_data      = bus.req_data[8*j +: 8];
        w_onehot[j] = 1'b1;
      end
    end
  end

  assign w_next_ptr = (r_owner == OW'(NREQ - 1)) ? '0 : r_owner + OW'(1);

`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0] r_cnt;
  logic        r_timeout_err;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_rr_ptr  <= '0;
      r_owner   <= '0;
      r_tx_data <= 8'h00;
      r_grant   <= '0;
      r_tx_wr   <= 1'b0;
      r_active  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      r_cnt         <= 16'd0;
      r_timeout_err <= 1'b0;
`endif
    end else begin
      r_grant <= '0;
      r_tx_wr <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      r_timeout_err <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (bus.en && (|bus.req)) begin
            r_state   <= LOAD;
            r_owner   <= w_winner;
            r_tx_data <= w_data;
            r_grant   <= w_onehot;
            r_tx_wr   <= 1'b1;
            r_active  <= 1'b1;
          end
        end
        LOAD: begin
          r_state <= WAIT_START;
`ifdef UART_ARB_TIMEOUT_EN
          r_cnt   <= 16'd0;
`endif
        end
        WAIT_START: begin
          if (bus.Tx_BUSY) begin
            r_state <= WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
          end else if (r_cnt == 16'(TIMEOUT_CYC - 1)) begin
            // Counter value TIMEOUT_CYC-1 here means TIMEOUT_CYC cycles elapsed.
            r_timeout_err <= 1'b1;
            r_state       <= IDLE;
            r_rr_ptr      <= w_next_ptr;
            r_active      <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
`endif
          end
        end
        WAIT_DONE: begin
          if (!bus.Tx_BUSY) begin
            r_state  <= IDLE;
            r_rr_ptr <= w_next_ptr;
            r_active <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.grant   = r_grant;
  assign bus.Tx_DATA = r_tx_data;
  assign bus.Tx_WR   = r_tx_wr;
  assign bus.owner   = r_owner;
  assign bus.active  = r_active;
`ifdef UART_ARB_TIMEOUT_EN
  assign bus.timeout_err = r_timeout_err;
`else
  assign bus.timeout_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_arbiter : scoreboard bench for uart_tx_arbiter (NREQ=4, TIMEOUT_CYC=8)
// Rev 1.0
// ============================================================================
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;

  logic clk;
  logic reset;

  uart_tx_arbiter_if #(.NREQ(NREQ)) ifc ();

  uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.master)
  );

  typedef struct {
    logic [3:0] grant;
    logic [1:0] owner;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   n_wr_seen = 0;
  int   last_wr_cyc = 0;
  int   n_to = 0;
  int   to_cyc = 0;
  int   busy_left = 0;
  logic busy_model_en = 1'b1;
  logic busy_kill = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // Transmitter model: busy for 10 cycles after every write strobe.
  initial begin
    ifc.Tx_BUSY = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (busy_kill) begin
        ifc.Tx_BUSY = 1'b0;
        busy_left   = 0;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) ifc.Tx_BUSY = 1'b0;
      end else if (busy_model_en && ifc.Tx_WR) begin
        ifc.Tx_BUSY = 1'b1;
        busy_left   = 10;
      end
    end
  end

  // Monitor: every write strobe or grant must match the next scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (ifc.Tx_WR || (ifc.grant != '0)) begin
        n_wr_seen++;
        last_wr_cyc = cyc;
        if (sb_q.size() == 0) begin
          chk("unexpected_write", {27'd0, ifc.Tx_WR, ifc.grant}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("grant", ifc.grant, e.grant);
          chk("tx_wr", ifc.Tx_WR, 1);
          chk("owner", ifc.owner, e.owner);
          chk("tx_data", ifc.Tx_DATA, e.data);
          if (e.cyc >= 0) chk("latency_cycle", cyc, e.cyc);
        end
      end
      if (ifc.timeout_err) begin
        n_to++;
        to_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [3:0] g, input logic [1:0] o, input logic [7:0] d, input int c);
    exp_t e;
    e.grant = g; e.owner = o; e.data = d; e.cyc = c;
    sb_q.push_back(e);
  endtask

  task automatic wait_grants(input int n, input int budget, input string name);
    int target;
    int k;
    target = n_wr_seen + n;
    k = 0;
    while (n_wr_seen < target && k < budget) begin
      tick();
      k++;
    end
    if (n_wr_seen < target) chk(name, n_wr_seen, target);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k;
    k = 0;
    while (ifc.active && k < budget) begin
      tick();
      k++;
    end
    if (ifc.active) chk(name, ifc.active, 0);
  endtask

  initial begin
    int g_cyc;
    int to_before;
    reset        = 1'b0;
    ifc.en       = 1'b1;
    ifc.req      = 4'b0000;
    ifc.req_data = {8'hD3, 8'hA5, 8'h5C, 8'h1E};
    #2;
    chk("rst_active", ifc.active, 0);
    chk("rst_tx_data", ifc.Tx_DATA, 8'h00);
    chk("rst_tx_wr", ifc.Tx_WR, 0);
    chk("rst_grant", ifc.grant, 0);
    chk("rst_owner", ifc.owner, 0);
    chk("rst_timeout_err", ifc.timeout_err, 0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Fairness: all four requesting, order 0,1,2,3,0.
    ifc.req = 4'b1111;
    push(4'b0001, 2'd0, 8'h1E, cyc + 1);
    push(4'b0010, 2'd1, 8'h5C, -1);
    push(4'b0100, 2'd2, 8'hA5, -1);
    push(4'b1000, 2'd3, 8'hD3, -1);
    push(4'b0001, 2'd0, 8'h1E, -1);
    wait_grants(5, 200, "fair_wait");
    ifc.req = 4'b0000;
    wait_idle(100, "fair_idle");

    // Single request from requester 2.
    tick();
    ifc.req = 4'b0100;
    push(4'b0100, 2'd2, 8'hA5, cyc + 1);
    wait_grants(1, 20, "single_wait");
    ifc.req = 4'b0000;
    tick(); tick(); tick();
    chk("tx_data_hold", ifc.Tx_DATA, 8'hA5);
    chk("active_busy", ifc.active, 1);
    wait_idle(100, "single_idle");

    // Wrap: pointer now 3, requesters 3 and 0.
    tick();
    ifc.req = 4'b1001;
    push(4'b1000, 2'd3, 8'hD3, cyc + 1);
    push(4'b0001, 2'd0, 8'h1E, -1);
    wait_grants(1, 20, "wrap_wait1");
    ifc.req = 4'b0001;
    wait_grants(1, 100, "wrap_wait2");
    ifc.req = 4'b0000;
    wait_idle(100, "wrap_idle");

    // Enable gating, then en dropped mid-transfer.
    tick();
    ifc.en  = 1'b0;
    ifc.req = 4'b0010;
    repeat (20) tick();
    chk("en_gated_active", ifc.active, 0);
    ifc.en = 1'b1;
    push(4'b0010, 2'd1, 8'h5C, cyc + 1);
    wait_grants(1, 20, "en_wait");
    ifc.req = 4'b0000;
    ifc.en  = 1'b0;
    wait_idle(100, "en_drop_idle");
    ifc.en = 1'b1;

    // Reset during WAIT_DONE.
    tick();
    ifc.req = 4'b0100;
    push(4'b0100, 2'd2, 8'hA5, cyc + 1);
    wait_grants(1, 20, "rst_mid_wait");
    ifc.req = 4'b0000;
    repeat (4) tick();
    chk("pre_rst_active", ifc.active, 1);
    #2;
    reset     = 1'b0;
    busy_kill = 1'b1;
    #1;
    chk("mid_rst_active", ifc.active, 0);
    chk("mid_rst_tx_data", ifc.Tx_DATA, 8'h00);
    chk("mid_rst_owner", ifc.owner, 0);
    chk("mid_rst_grant", ifc.grant, 0);
    tick(); tick();
    reset = 1'b1;
    tick();
    busy_kill = 1'b0;
    ifc.req = 4'b0001;
    push(4'b0001, 2'd0, 8'h1E, cyc + 1);
    wait_grants(1, 20, "post_rst_wait");
    ifc.req = 4'b0000;
    wait_idle(100, "post_rst_idle");

    // Start timeout: transmitter never goes busy.
    tick();
    busy_model_en = 1'b0;
    to_before = n_to;
    ifc.req = 4'b1000;
    push(4'b1000, 2'd3, 8'hD3, cyc + 1);
    wait_grants(1, 20, "to_wait");
    g_cyc = last_wr_cyc;
    ifc.req = 4'b0000;
    repeat (14) tick();
`ifdef UART_ARB_TIMEOUT_EN
    chk("timeout_pulses", n_to - to_before, 1);
    chk("timeout_cycle", to_cyc, g_cyc + 9);
    chk("timeout_active", ifc.active, 0);
`else
    chk("no_timeout_pulses", n_to - to_before, 0);
    chk("no_timeout_active", ifc.active, 1);
`endif

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: NREQ, 4, number of requesters; legal values 2..8.
REQ-002 Parameter: TIMEOUT_CYC, 1023, maximum cycles WAIT_START waits for Tx_BUSY; legal range 1..65535.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: en  input  1  arbitration enable; when low, no new grant is issued.
REQ-006 Port: req  input  NREQ  per-requester request level; held high with data stable until that requester's grant.
REQ-007 Port: req_data  input  8*NREQ  byte for requester i, located at bits [8i+7:8i].
REQ-008 Port: grant  output  NREQ  one-hot, one-cycle pulse marking the byte handed to the transmitter.
REQ-009 Port: Tx_DATA  output  8  byte presented to the UART transmitter.
REQ-010 Port: Tx_WR  output  1  one-cycle write strobe to the transmitter.
REQ-011 Port: Tx_BUSY  input  1  transmitter busy; high while a frame is being sent.
REQ-012 Port: owner  output  clog2(NREQ)  index of the current or last granted requester.
REQ-013 Port: active  output  1  high in every state except IDLE.
REQ-014 Port: timeout_err  output  1  one-cycle pulse when the timeout fires.

Function
REQ-015 The FSM SHALL have the states IDLE, LOAD, WAIT_START and WAIT_DONE, encoded in a registered state variable.
REQ-016 IDLE: if en=1 and req!=0, the block SHALL do the following at the clock edge and then go to LOAD:
- select the winner as the first set bit of req, searching upward from rr_ptr with wrap from NREQ-1 to 0;
- register owner with the winner's index;
- register Tx_DATA with req_data[owner].
REQ-017 IDLE: if en=0 or req=0, the block SHALL stay in IDLE with Tx_WR=0 and grant=0.
REQ-018 LOAD: the block SHALL drive Tx_WR=1 and grant[owner]=1 for exactly one cycle, then go to WAIT_START.
REQ-019 Latency: Tx_WR SHALL be high in the second cycle after req is first sampled high in IDLE.
REQ-020 WAIT_START: Tx_BUSY=1 SHALL move the FSM to WAIT_DONE.
REQ-021 WAIT_DONE: Tx_BUSY=0 SHALL move the FSM to IDLE and set rr_ptr=(owner+1) mod NREQ.
REQ-022 Tx_DATA SHALL hold its value from LOAD until the next LOAD.
REQ-023 Requests that arrive or drop while not in IDLE SHALL be ignored until the FSM returns to IDLE.
REQ-024 Simultaneous requests SHALL be served round-robin, so no requester waits more than NREQ-1 grants.
REQ-025 If en falls mid-transfer, the current transfer SHALL complete, and en SHALL gate only the IDLE-to-LOAD transition.
REQ-026 If Tx_BUSY is already high on entry to WAIT_START, the FSM SHALL go to WAIT_DONE on the next edge.
REQ-027 grant and Tx_WR SHALL never be high outside LOAD.

Reset
REQ-028 When reset=0, all outputs and state SHALL clear immediately, independent of clk: state=IDLE, rr_ptr=0, owner=0, Tx_DATA=0x00, Tx_WR=0, grant=0, active=0, timeout_err=0, timeout counter=0.
REQ-029 Reset asserted mid-transfer SHALL abandon the transfer, with no grant reissued for it.
REQ-030 After reset rises, the first grant SHALL take effect no earlier than the first clock edge.

Configuration
REQ-031 With UART_ARB_TIMEOUT_EN defined, the timeout SHALL behave as follows:
- a 16-bit counter clears on entry to WAIT_START and increments each cycle spent there;
- when the counter reaches TIMEOUT_CYC without Tx_BUSY, the block pulses timeout_err for one cycle, goes to IDLE and sets rr_ptr=(owner+1) mod NREQ.
REQ-032 With UART_ARB_TIMEOUT_EN undefined, WAIT_START SHALL wait indefinitely, timeout_err SHALL be tied to 0, and no counter logic SHALL be synthesized.

Verification
REQ-033 Single request: req=4'b0100, req_data byte2=0xA5 -> owner=2, Tx_DATA=0xA5, grant=4'b0100 and Tx_WR high in the same single cycle, 2 cycles after req.
REQ-034 Fairness: req=4'b1111 held through four transfers with Tx_BUSY modelled 10 cycles each -> grant order 0,1,2,3, then 0 again on the fifth transfer.
REQ-035 Wrap: rr_ptr=3 with req=4'b1001 -> grant 3 first, then 0.
REQ-036 Enable gating: en=0 with req=4'b0010 for 20 cycles -> no Tx_WR; en=1 -> grant[1] pulse 2 cycles later.
REQ-037 Reset mid-transfer: reset=0 during WAIT_DONE -> immediate IDLE, Tx_DATA=0x00, active=0; after release with req=4'b0001 -> grant[0].
REQ-038 Timeout (macro defined, TIMEOUT_CYC=8): Tx_BUSY held 0 after grant -> timeout_err pulses once, 8 cycles after entering WAIT_START, and active drops to 0; with the macro undefined, active stays 1.
